// File: rtl/drawing_priority_n.sv
// N-layer drawing priority mux with colour-key transparency, collision detection
// and per-frame sticky hit flags, through a fixed 2-stage registered pipeline.
module drawing_priority_n #(
    parameter int unsigned N      = 4,
    parameter int unsigned CW     = 4,
    parameter bit          KEY_EN = 1'b1,
    parameter logic [3*CW-1:0] KEY = 12'h0F0,
    localparam int unsigned PW    = 3 * CW,
    localparam int unsigned TW    = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [N*PW-1:0] layer_rgb,
    input  logic [N-1:0]    layer_draw,
    input  logic [N-1:0]    layer_en,
    input  logic [PW-1:0]   bg_rgb,
    input  logic            frame_start,
    output logic [CW-1:0]   Red_level,
    output logic [CW-1:0]   Green_level,
    output logic [CW-1:0]   Blue_level,
    output logic            draw_any,
    output logic [TW-1:0]   top_layer,
    output logic            collision_pix,
    output logic [N-1:0]    layer_hit_frame,
    output logic            frame_done
);

    logic [N-1:0]    qd_c;
    logic [N-1:0]    hit_c;
    logic            coll_c;
    int unsigned     cnt_c;

    logic [N-1:0]    qd1;
    logic [N*PW-1:0] rgb1;
    logic [PW-1:0]   bg1;
    logic            fs1;
    logic [N-1:0]    hit1;
    logic            coll1;

    logic [N-1:0]    hit_acc;

    logic            found_c;
    logic [TW-1:0]   win_c;
    logic [PW-1:0]   sel_c;

    // Qualify each layer: drawn, enabled and not the transparent key colour.
    always_comb begin
        qd_c  = '0;
        cnt_c = 0;
        for (int unsigned i = 0; i < N; i++) begin
            qd_c[i] = layer_draw[i] & layer_en[i]
                      & !(KEY_EN && (layer_rgb[i*PW +: PW] == KEY));
            cnt_c   = cnt_c + 32'(qd_c[i]);
        end
        coll_c = (cnt_c >= 2);
        hit_c  = coll_c ? qd_c : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            qd1   <= '0;
            rgb1  <= '0;
            bg1   <= '0;
            fs1   <= 1'b0;
            hit1  <= '0;
            coll1 <= 1'b0;
        end else begin
            qd1   <= qd_c;
            rgb1  <= layer_rgb;
            bg1   <= bg_rgb;
            fs1   <= frame_start;
            hit1  <= hit_c;
            coll1 <= coll_c;
        end
    end

    // Lowest qualified index wins; scan downwards so the last hit is the lowest.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        sel_c   = bg1;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (qd1[i]) begin
                found_c = 1'b1;
                win_c   = TW'(i);
                sel_c   = rgb1[i*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            Red_level       <= '0;
            Green_level     <= '0;
            Blue_level      <= '0;
            draw_any        <= 1'b0;
            top_layer       <= '0;
            collision_pix   <= 1'b0;
            hit_acc         <= '0;
            layer_hit_frame <= '0;
            frame_done      <= 1'b0;
        end else begin
            Red_level     <= sel_c[3*CW-1 -: CW];
            Green_level   <= sel_c[2*CW-1 -: CW];
            Blue_level    <= sel_c[CW-1   -: CW];
            draw_any      <= found_c;
            top_layer     <= win_c;
            collision_pix <= coll1;
            // The frame_start pixel opens the new frame, so its hits seed the accumulator.
            if (fs1) begin
                layer_hit_frame <= hit_acc;
                hit_acc         <= hit1;
                frame_done      <= 1'b1;
            end else begin
                hit_acc         <= hit_acc | hit1;
                frame_done      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drawing_priority_n.sv
// Self-checking bench for drawing_priority_n (N=4, CW=4): directed scenarios plus
// randomized pixels checked against a pixel-level reference model.
module tb_drawing_priority_n;

    localparam logic [11:0] KEY = 12'h0F0;

    logic        clk = 1'b0;
    logic        resetN;
    logic [47:0] layer_rgb;
    logic [3:0]  layer_draw;
    logic [3:0]  layer_en;
    logic [11:0] bg_rgb;
    logic        frame_start;
    logic [3:0]  Red_level, Green_level, Blue_level;
    logic        draw_any;
    logic [1:0]  top_layer;
    logic        collision_pix;
    logic [3:0]  layer_hit_frame;
    logic        frame_done;

    drawing_priority_n #(.N(4), .CW(4), .KEY_EN(1'b1), .KEY(KEY)) dut (
        .clk(clk), .resetN(resetN), .layer_rgb(layer_rgb), .layer_draw(layer_draw),
        .layer_en(layer_en), .bg_rgb(bg_rgb), .frame_start(frame_start),
        .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
        .draw_any(draw_any), .top_layer(top_layer), .collision_pix(collision_pix),
        .layer_hit_frame(layer_hit_frame), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] rgb;
        logic [3:0]  draw;
        logic [3:0]  en;
        logic [11:0] bg;
        logic        fs;
    } pix_t;

    int tests = 0;
    int fails = 0;

    pix_t        pend;
    logic [11:0] e_rgb;
    logic        e_da, e_coll, e_fd;
    logic [1:0]  e_top;
    logic [3:0]  e_lhf, acc;

    // Reference: resolve one pixel from the rules and advance the frame bookkeeping.
    function automatic void resolve(input pix_t p);
        logic [3:0] qd;
        logic [3:0] hit;
        int         pc;
        int         win;
        for (int i = 0; i < 4; i++)
            qd[i] = p.draw[i] && p.en[i] && (p.rgb[i*12 +: 12] != KEY);
        pc  = $countones(qd);
        hit = (pc >= 2) ? qd : 4'b0000;
        win = -1;
        for (int i = 0; i < 4 && win < 0; i++)
            if (qd[i]) win = i;
        e_rgb  = (win >= 0) ? p.rgb[win*12 +: 12] : p.bg;
        e_da   = (win >= 0);
        e_top  = (win >= 0) ? 2'(win) : 2'd0;
        e_coll = (pc >= 2);
        if (p.fs) begin
            e_lhf = acc;
            acc   = hit;
            e_fd  = 1'b1;
        end else begin
            acc   = acc | hit;
            e_fd  = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with what the DUT sees, then compare after the edge.
    task automatic step();
        pix_t cur;
        cur = '{rgb: layer_rgb, draw: layer_draw, en: layer_en, bg: bg_rgb, fs: frame_start};
        @(posedge clk);
        if (!resetN) begin
            pend  = '0;
            e_rgb = '0; e_da = 1'b0; e_top = '0; e_coll = 1'b0;
            e_lhf = '0; e_fd = 1'b0; acc = '0;
        end else begin
            resolve(pend);
            pend = cur;
        end
        #1;
        check("rgb", 32'({Red_level, Green_level, Blue_level}), 32'(e_rgb));
        check("draw_any", 32'(draw_any), 32'(e_da));
        check("top_layer", 32'(top_layer), 32'(e_top));
        check("collision_pix", 32'(collision_pix), 32'(e_coll));
        check("layer_hit_frame", 32'(layer_hit_frame), 32'(e_lhf));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic set_pix(input logic [3:0] draw, input logic [3:0] en,
                           input logic [47:0] rgb, input logic [11:0] bg, input logic fs);
        layer_draw  = draw;
        layer_en    = en;
        layer_rgb   = rgb;
        bg_rgb      = bg;
        frame_start = fs;
    endtask

    initial begin
        pend = '0; acc = '0;
        e_rgb = '0; e_da = 1'b0; e_top = '0; e_coll = 1'b0; e_lhf = '0; e_fd = 1'b0;
        resetN = 1'b0;
        set_pix(4'h0, 4'h0, 48'h0, 12'h0, 1'b0);
        step();
        step();
        check("reset_rgb", 32'({Red_level, Green_level, Blue_level}), 32'h0);
        resetN = 1'b1;

        // Background fallback
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b0);
        step(); step();
        check("t1_rgb", 32'({Red_level, Green_level, Blue_level}), 32'h123);
        check("t1_draw_any", 32'(draw_any), 32'h0);

        // Layer 1 beats layer 2, collision flagged
        set_pix(4'b0110, 4'hF, 48'h000_00F_F00_000, 12'h123, 1'b0);
        step(); step();
        check("t2_rgb", 32'({Red_level, Green_level, Blue_level}), 32'hF00);
        check("t2_top", 32'(top_layer), 32'h1);
        check("t2_coll", 32'(collision_pix), 32'h1);

        // Layer 1 disabled
        set_pix(4'b0110, 4'b1101, 48'h000_00F_F00_000, 12'h123, 1'b0);
        step(); step();
        check("t3_rgb", 32'({Red_level, Green_level, Blue_level}), 32'h00F);
        check("t3_top", 32'(top_layer), 32'h2);
        check("t3_coll", 32'(collision_pix), 32'h0);

        // Layer 0 keyed out
        set_pix(4'b0011, 4'hF, 48'h000_000_ABC_0F0, 12'h123, 1'b0);
        step(); step();
        check("t4_rgb", 32'({Red_level, Green_level, Blue_level}), 32'hABC);
        check("t4_top", 32'(top_layer), 32'h1);
        check("t4_coll", 32'(collision_pix), 32'h0);

        // Frame accounting
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b1); step();
        set_pix(4'b1001, 4'hF, 48'h222_000_000_111, 12'h123, 1'b0); step();
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b0); step();
        set_pix(4'b0110, 4'hF, 48'h000_333_444_000, 12'h123, 1'b1); step();
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b0); step();
        check("t5_done1", 32'(frame_done), 32'h1);
        check("t5_hits1", 32'(layer_hit_frame), 32'h9);
        step(); step();
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b1); step();
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b0); step();
        check("t5_done2", 32'(frame_done), 32'h1);
        check("t5_hits2", 32'(layer_hit_frame), 32'h6);

        // Reset mid-frame discards the accumulation
        set_pix(4'b1001, 4'hF, 48'h222_000_000_111, 12'h123, 1'b0); step(); step();
        resetN = 1'b0; step();
        check("t6_rgb", 32'({Red_level, Green_level, Blue_level}), 32'h0);
        check("t6_coll", 32'(collision_pix), 32'h0);
        resetN = 1'b1;
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b1); step();
        set_pix(4'b0000, 4'hF, 48'h0, 12'h123, 1'b0); step();
        check("t6_done", 32'(frame_done), 32'h1);
        check("t6_hits", 32'(layer_hit_frame), 32'h0);

        // Randomized pixels, frames and occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [47:0] rgb;
            for (int i = 0; i < 4; i++)
                rgb[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
            set_pix(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
                    rgb, 12'($urandom), ($urandom_range(0, 15) == 0));
            resetN = ($urandom_range(0, 99) != 0);
            step();
        end
        resetN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/drawing_priority_n.md
Name: drawing_priority_n

Overview:
- Parametrised successor of the two-layer drawing priority mux.
- Selects the highest-priority drawn pixel among N sprite layers, with a background fallback, through a fixed 2-stage registered pipeline.
- Adds per-layer enable, a transparent colour key, per-pixel collision detection and per-frame sticky per-layer hit flags, so game logic can read collisions once per frame.
- Sits between the object units and the screen controller, in place of the 2-input mux.

Parameters:
N, 4, number of sprite layers (2..8); layer 0 has the highest priority.
CW, 4, bits per colour channel; a pixel is 3*CW bits, ordered {R,G,B}.
KEY_EN, 1, 1 = a pixel equal to KEY is treated as not drawn.
KEY, 12'h0F0, transparent key colour (3*CW bits).

Ports:
clk  in  1  pixel clock.
resetN  in  1  synchronous active-low reset.
layer_rgb  in  N*3*CW  layer i colour at bits [(i+1)*3*CW-1 : i*3*CW].
layer_draw  in  N  layer i claims this pixel.
layer_en  in  N  layer i enable; 0 = layer ignored.
bg_rgb  in  3*CW  background colour.
frame_start  in  1  1-cycle pulse, coincident with the first pixel of a frame.
Red_level  out  CW  selected red.
Green_level  out  CW  selected green.
Blue_level  out  CW  selected blue.
draw_any  out  1  some layer won this pixel.
top_layer  out  max(1,$clog2(N))  index of the winning layer; 0 if none.
collision_pix  out  1  two or more qualified layers overlap on this pixel.
layer_hit_frame  out  N  layers that collided during the last completed frame.
frame_done  out  1  1-cycle pulse when layer_hit_frame updates.

Behaviour:
- All registers are reset synchronously: on any clk edge with resetN=0, every output and internal register goes to 0. This includes the stage-1 registers, the hit accumulator, layer_hit_frame and frame_done.
- Reset mid-frame discards the partial accumulation; no frame_done is issued for that frame.
- Qualification: qd[i] = layer_draw[i] & layer_en[i] & ~(KEY_EN & layer_rgb_i == KEY).
- Stage 1 (edge t+1) registers:
  - qd;
  - all layer RGBs and bg_rgb;
  - frame_start;
  - hit_now[i] = qd[i] & (popcount(qd) >= 2);
  - coll = popcount(qd) >= 2.
- Stage 2 (edge t+2) registers the outputs from the stage-1 values:
  - winner = the lowest index i with qd[i]=1.
  - If a winner exists: {R,G,B} = that layer's RGB, draw_any=1, top_layer=winner.
  - Otherwise: {R,G,B} = bg_rgb, draw_any=0, top_layer=0.
  - collision_pix = coll.
- Latency: exactly 2 clk cycles from inputs to every pixel output. There is no stall and no backpressure; a new pixel is accepted every cycle.
- Frame accumulation, evaluated at stage 2 using the stage-1 frame_start (fs1):
  - fs1=0: hit_acc <= hit_acc | hit_now; frame_done <= 0.
  - fs1=1: layer_hit_frame <= hit_acc; hit_acc <= hit_now; frame_done <= 1.
  - The pixel in the frame_start cycle belongs to the new frame.
  - Consequently layer_hit_frame and frame_done update 2 cycles after the frame_start input.
- The first frame_start after reset publishes all-zeros (there is no previous frame).
- Back-to-back frame_start pulses: each pulse publishes the accumulation since the previous one. This can be a single pixel's hit_now.
- layer_en change takes effect on the pixel presented in the same cycle; there is no retiming.
- A disabled or keyed layer contributes to neither priority nor collision.
- Arithmetic: popcount is N-bit, compared against the constant 2. All selection is bitwise; there is no colour blending.

Test Plan:
1. Reset, then one pixel with N=4, all draw=0, bg=12'h123 → after 2 cycles RGB=1,2,3, draw_any=0, top_layer=0, collision_pix=0.
2. draw=4'b0110, layer1=12'hF00, layer2=12'h00F, en=4'hF → 2 cycles later RGB=F,0,0, top_layer=1, collision_pix=1.
3. Same as 2 with en=4'b1101 → RGB=0,0,F, top_layer=2, collision_pix=0.
4. draw=4'b0011, layer0=KEY(12'h0F0), layer1=12'hABC → RGB=A,B,C, top_layer=1, collision_pix=0.
5. frame_start, then a collision of layers 0 and 3 mid-frame, then frame_start with a layer1+layer2 collision on that same cycle → second frame_done shows layer_hit_frame=4'b1001; the third frame_start publishes 4'b0110.
6. resetN low for one cycle mid-frame after collisions → outputs all 0 next cycle; the next frame_start publishes 4'b0000.
